// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO registers.
//   mult: shift-add, one multiplier bit per cycle.
//   div: restoring division, one quotient bit per cycle.
//   mthi/mtlo: write HI/LO directly from operand a, single cycle, never busy.
// Optional feature: define MDU_SIGNED_EN to honour sgn (signed mult/div via magnitudes
// plus a sign fix in FIN). Without it sgn is ignored and no sign logic exists.
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   start, op, sgn request strobe, 00 mult / 01 div / 10 mthi / 11 mtlo, signed select
//   a, b           operands (rs, rt)
//   busy           high in MUL, DIV and FIN
//   done, divzero  one-cycle pulses after hi/lo are updated by mult/div
//   hi, lo         HI/LO registers
module mdu_iter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNTBITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

    localparam logic [CNTBITS-1:0] LastCnt = CNTBITS'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNTBITS-1:0] count_q, count_d;
    // acc: upper product half / partial remainder; low: multiplier / dividend -> quotient
    logic [WIDTH-1:0]   acc_q, acc_d, low_q, low_d, opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic               isdiv_q, isdiv_d, bzero_q, bzero_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_res;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [2*WIDTH-1:0] prod;

`ifdef MDU_SIGNED_EN
    logic sa_q, sa_d, sb_q, sb_d;
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
`endif

    always_comb begin
        add_sum = {1'b0, acc_q} + (low_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
        // Partial remainder is below the divisor, so WIDTH+1 bits hold the shifted value;
        // bit WIDTH of the difference is the borrow.
        sub_res = {acc_q, low_q[WIDTH-1]} - {1'b0, opb_q};
        a_mag   = a;
        b_mag   = b;
        prod    = {acc_q, low_q};
        quo     = low_q;
        rem     = acc_q;
`ifdef MDU_SIGNED_EN
        if (sgn && a[WIDTH-1]) a_mag = -a;
        if (sgn && b[WIDTH-1]) b_mag = -b;
        if (sa_q ^ sb_q) begin
            prod = -{acc_q, low_q};
            quo  = -low_q;
        end
        if (sa_q) rem = -acc_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        low_d   = low_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        isdiv_d = isdiv_q;
        bzero_d = bzero_q;
`ifdef MDU_SIGNED_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    unique case (op)
                        2'b00, 2'b01: begin
                            acc_d   = '0;
                            low_d   = a_mag;
                            opb_d   = b_mag;
                            count_d = '0;
                            busy_d  = 1'b1;
                            isdiv_d = op[0];
                            bzero_d = (b == '0);
                            state_d = op[0] ? StDiv : StMul;
`ifdef MDU_SIGNED_EN
                            sa_d    = sgn & a[WIDTH-1];
                            sb_d    = sgn & b[WIDTH-1];
`endif
                        end
                        2'b10: hi_d = a;
                        2'b11: lo_d = a;
                    endcase
                end
            end
            StMul: begin
                {acc_d, low_d} = {add_sum, low_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                if (count_q == LastCnt) state_d = StFin;
            end
            StDiv: begin
                acc_d   = sub_res[WIDTH] ? {acc_q[WIDTH-2:0], low_q[WIDTH-1]} : sub_res[WIDTH-1:0];
                low_d   = {low_q[WIDTH-2:0], ~sub_res[WIDTH]};
                count_d = count_q + 1'b1;
                if (count_q == LastCnt) state_d = StFin;
            end
            StFin: begin
                if (isdiv_q) begin
                    hi_d = rem;
                    lo_d = quo;
                    dz_d = bzero_q;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            acc_q   <= '0;
            low_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            isdiv_q <= 1'b0;
            bzero_q <= 1'b0;
`ifdef MDU_SIGNED_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            low_q   <= low_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            isdiv_q <= isdiv_d;
            bzero_q <= bzero_d;
`ifdef MDU_SIGNED_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign divzero = dz_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (table vectors, hand sequences, random
// operations against an arithmetic reference model).
module tb_mdu_iter;
    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        divzero;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    mdu_iter #(.WIDTH(32), .CNTBITS(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
        .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic on magnitudes, then the sign rules.
    function automatic void model(input logic [1:0] o, input logic s, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] rh,
                                  output logic [31:0] rl, output logic rdz);
        logic [31:0] mx, my, q, r;
        logic        nx, ny;
        logic [63:0] p;
        mx = x;
        my = y;
`ifdef MDU_SIGNED_EN
        nx = s & x[31];
        ny = s & y[31];
        if (nx) mx = -x;
        if (ny) my = -y;
`else
        nx = 1'b0 & s;
        ny = 1'b0;
`endif
        rh  = model_hi;
        rl  = model_lo;
        rdz = 1'b0;
        case (o)
            2'b00: begin
                p = 64'(mx) * 64'(my);
                if (nx ^ ny) p = -p;
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                if (my == 32'h0) begin
                    q   = 32'hFFFF_FFFF;
                    r   = mx;
                    rdz = 1'b1;
                end else begin
                    q = mx / my;
                    r = mx % my;
                end
                if (nx ^ ny) q = -q;
                if (nx) r = -r;
                rh = r;
                rl = q;
            end
            2'b10: rh = x;
            default: rl = x;
        endcase
    endfunction

    // Called #1 after a posedge. inj >= 0 pulses an mthi of 0xDEAD that many cycles in.
    task automatic run_op(input logic [1:0] o, input logic s, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz, input string nm, input int inj);
        int   n;
        logic holdbad;
        start = 1'b1;
        op    = o;
        sgn   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sgn   = ~s;
        if (o[1]) begin
            check({nm, " hi"}, hi, eh);
            check({nm, " lo"}, lo, el);
            check({nm, " busy/done"}, {30'h0, busy, done}, 32'h0);
        end else begin
            n       = 0;
            holdbad = 1'b0;
            while (!done && n < 60) begin
                if (busy !== 1'b1 || hi !== model_hi || lo !== model_lo) holdbad = 1'b1;
                if (n == inj) begin
                    start = 1'b1;
                    op    = 2'b10;
                    a     = 32'h0000_DEAD;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1;
                n++;
            end
            start = 1'b0;
            check({nm, " latency"}, n, 33);
            check({nm, " busy/hold while running"}, {31'h0, holdbad}, 32'h0);
            check({nm, " hi"}, hi, eh);
            check({nm, " lo"}, lo, el);
            check({nm, " divzero"}, {31'h0, divzero}, {31'h0, edz});
            check({nm, " busy after"}, {31'h0, busy}, 32'h0);
            @(posedge clk);
            #1;
            check({nm, " done/divzero pulse"}, {30'h0, done, divzero}, 32'h0);
        end
        model_hi = eh;
        model_lo = el;
    endtask

    initial begin
        logic [31:0] eh, el, x, y;
        logic        ed, s;
        logic [1:0]  o;
        int          dn;

        vecs[0]  = '{2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b01, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        vecs[2]  = '{2'b01, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1};
        vecs[3]  = '{2'b00, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0};
        vecs[4]  = '{2'b00, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0};
        vecs[5]  = '{2'b01, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0};
        vecs[6]  = '{2'b01, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0, 1'b0};
        vecs[7]  = '{2'b00, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 1'b0};
        vecs[8]  = '{2'b01, 1'b0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{2'b00, 1'b0, 32'h8000_0000, 32'h2, 32'h1, 32'h0, 1'b0};
        vecs[10] = '{2'b01, 1'b0, 32'hDEAD_BEEF, 32'h1, 32'h0, 32'hDEAD_BEEF, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        sgn   = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        #12;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy/done/divzero", {29'h0, busy, done, divzero}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // mthi then mtlo on consecutive edges
        start = 1'b1;
        op    = 2'b10;
        a     = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("mthi hi", hi, 32'h1234_5678);
        check("mthi busy/done", {30'h0, busy, done}, 32'h0);
        op = 2'b11;
        a  = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mtlo hi", hi, 32'h1234_5678);
        check("mtlo lo", lo, 32'h9ABC_DEF0);
        check("mtlo busy/done", {30'h0, busy, done}, 32'h0);
        model_hi = 32'h1234_5678;
        model_lo = 32'h9ABC_DEF0;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo,
                   vecs[i].edz, $sformatf("vec%0d", i), -1);
        end

        // mthi while busy must be ignored
        run_op(2'b00, 1'b0, 32'h1234, 32'h10, 32'h0, 32'h0001_2340, 1'b0, "mult+ignored mthi", 5);

        // reset in the middle of a div
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        model_hi = 32'h0;
        model_lo = 32'h0;
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("no done after abort", dn, 0);
        run_op(2'b00, 1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, "mult after abort", -1);

`ifdef MDU_SIGNED_EN
        run_op(2'b00, 1'b1, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, "smul -3*5", -1);
        run_op(2'b01, 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "sdiv -7/2", -1);
`endif

        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            model(o, s, x, y, eh, el, ed);
            run_op(o, s, x, y, eh, el, ed, $sformatf("rand%0d op%0d", i, o), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
